// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the fabric configuration loader.
// State encoding, default geometry and LUT cell indices used by loader and benches.
package fpga_cfg_pkg;

    localparam int NUM_LUT_DEF    = 20;
    localparam int SKIP_WORDS_DEF = 3;
    localparam int WORD_W_DEF     = 32;
    localparam int LUT_W_DEF      = 33;
    localparam int ADDR_W         = 5;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        LOW,
        HIGH,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam logic [ADDR_W-1:0] LT0A = 5'd0;
    localparam logic [ADDR_W-1:0] LT1A = 5'd1;
    localparam logic [ADDR_W-1:0] LT2A = 5'd2;
    localparam logic [ADDR_W-1:0] LT3A = 5'd3;
    localparam logic [ADDR_W-1:0] LT4A = 5'd4;
    localparam logic [ADDR_W-1:0] LT5A = 5'd5;
    localparam logic [ADDR_W-1:0] LT6A = 5'd6;
    localparam logic [ADDR_W-1:0] LT7A = 5'd7;
    localparam logic [ADDR_W-1:0] LT0B = 5'd8;
    localparam logic [ADDR_W-1:0] LT1B = 5'd9;
    localparam logic [ADDR_W-1:0] LT2B = 5'd10;
    localparam logic [ADDR_W-1:0] LT3B = 5'd11;
    localparam logic [ADDR_W-1:0] LT4B = 5'd12;
    localparam logic [ADDR_W-1:0] LT5B = 5'd13;
    localparam logic [ADDR_W-1:0] LT6B = 5'd14;
    localparam logic [ADDR_W-1:0] LT7B = 5'd15;
    localparam logic [ADDR_W-1:0] S1   = 5'd16;
    localparam logic [ADDR_W-1:0] S2   = 5'd17;
    localparam logic [ADDR_W-1:0] S3   = 5'd18;
    localparam logic [ADDR_W-1:0] CO   = 5'd19;

    // Parity bit expected alongside a LUT payload: XOR reduction of the payload.
    function automatic logic lut_parity(input logic [LUT_W_DEF-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/cfg_parity_chk.sv
// Combinational parity check of an assembled LUT payload against its carried parity bit.
// Zero latency, no flow control; ok=1 when the parity bit equals the payload XOR.
module cfg_parity_chk
    import fpga_cfg_pkg::*;
(
    input  logic [LUT_W_DEF-1:0] data,
    input  logic                 par,
    output logic                 ok
);

    logic w_exp_par;

    assign w_exp_par = lut_parity(data);
    assign ok        = (w_exp_par == par);

endmodule

// File: rtl/fpga_cfg_loader.sv
// Streams header + (low, high) word pairs into the fabric LUT write port; one write per pair, 3 cycles/LUT.
// word_ready drops only during the write cycle; CFG_PARITY_EN enables high-word parity checking and the ERR path.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int NUM_LUT    = NUM_LUT_DEF,
    parameter int SKIP_WORDS = SKIP_WORDS_DEF,
    parameter int WORD_W     = WORD_W_DEF,
    parameter int LUT_W      = LUT_W_DEF
)(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                word_valid,
    input  logic [WORD_W-1:0]   word_data,
    output logic                word_ready,
    output logic                cfg_we,
    output logic [ADDR_W-1:0]   cfg_addr,
    output logic [LUT_W-1:0]    cfg_data,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int SKIP_CW = (SKIP_WORDS > 1) ? $clog2(SKIP_WORDS) : 1;
    localparam logic [SKIP_CW-1:0] SKIP_LAST = SKIP_CW'((SKIP_WORDS > 0) ? SKIP_WORDS - 1 : 0);
    localparam logic [ADDR_W-1:0]  LAST_IDX  = ADDR_W'(NUM_LUT - 1);
    localparam state_t             FIRST_ST  = (SKIP_WORDS > 0) ? SKIP : LOW;

    state_t               r_state;
    logic [SKIP_CW-1:0]   r_skip_cnt;
    logic [ADDR_W-1:0]    r_idx;
    logic [WORD_W-1:0]    r_low;
    logic                 r_word_ready;
    logic                 r_cfg_we;
    logic [ADDR_W-1:0]    r_cfg_addr;
    logic [LUT_W-1:0]     r_cfg_data;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;

    logic                 w_accept;
    logic                 w_par_err;

    assign w_accept = word_valid & r_word_ready;

`ifdef CFG_PARITY_EN
    logic w_par_ok;

    cfg_parity_chk u_par_chk (
        .data (LUT_W_DEF'({word_data[0], r_low})),
        .par  (word_data[WORD_W-1]),
        .ok   (w_par_ok)
    );

    assign w_par_err = ~w_par_ok;
`else
    assign w_par_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_skip_cnt   <= '0;
            r_idx        <= '0;
            r_low        <= '0;
            r_word_ready <= 1'b0;
            r_cfg_we     <= 1'b0;
            r_cfg_addr   <= '0;
            r_cfg_data   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_cfg_we <= 1'b0;
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        r_state      <= FIRST_ST;
                        r_skip_cnt   <= '0;
                        r_idx        <= '0;
                        r_cfg_addr   <= '0;
                        r_word_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                    end
                end
                SKIP: begin
                    if (w_accept) begin
                        if (r_skip_cnt == SKIP_LAST) begin
                            r_state <= LOW;
                        end else begin
                            r_skip_cnt <= r_skip_cnt + 1'b1;
                        end
                    end
                end
                LOW: begin
                    if (w_accept) begin
                        r_low   <= word_data;
                        r_state <= HIGH;
                    end
                end
                HIGH: begin
                    if (w_accept) begin
                        r_word_ready <= 1'b0;
                        if (w_par_err) begin
                            r_state <= ERR;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end else begin
                            r_state    <= WRITE;
                            r_cfg_we   <= 1'b1;
                            r_cfg_addr <= r_idx;
                            r_cfg_data <= LUT_W'({word_data[0], r_low});
                        end
                    end
                end
                WRITE: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx        <= r_idx + 1'b1;
                        r_state      <= LOW;
                        r_word_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_word_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign word_ready = r_word_ready;
    assign cfg_we     = r_cfg_we;
    assign cfg_addr   = r_cfg_addr;
    assign cfg_data   = r_cfg_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader: default geometry plus a 1-LUT, no-header instance.
module tb_fpga_cfg_loader;
    import fpga_cfg_pkg::*;

    logic        clock = 1'b0;
    logic        reset, start, word_valid;
    logic [31:0] word_data;
    logic        word_ready, cfg_we, busy, done, error;
    logic [4:0]  cfg_addr;
    logic [32:0] cfg_data;

    logic        s_start, s_valid;
    logic [31:0] s_wdata;
    logic        s_ready, s_we, s_busy, s_done, s_error;
    logic [4:0]  s_addr;
    logic [32:0] s_cdata;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] mem [43];
    int          wr_n = 0;
    logic [4:0]  wr_addr [512];
    logic [32:0] wr_data [512];

    always #5 clock = ~clock;

    fpga_cfg_loader dut (
        .clock(clock), .reset(reset), .start(start),
        .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .busy(busy), .done(done), .error(error)
    );

    fpga_cfg_loader #(.NUM_LUT(1), .SKIP_WORDS(0)) dut_small (
        .clock(clock), .reset(reset), .start(s_start),
        .word_valid(s_valid), .word_data(s_wdata), .word_ready(s_ready),
        .cfg_we(s_we), .cfg_addr(s_addr), .cfg_data(s_cdata),
        .busy(s_busy), .done(s_done), .error(s_error)
    );

    // Write monitor: logs every strobe of the main instance.
    initial begin
        forever begin
            @(negedge clock);
            if (cfg_we === 1'b1) begin
                if (wr_n < 512) begin
                    wr_addr[wr_n] = cfg_addr;
                    wr_data[wr_n] = cfg_data;
                end
                wr_n++;
            end
        end
    end

    // One load on the main instance; returns the edge index (after start) at which done rose,
    // -1 on timeout, -2 when aborted by reset at edge rst_at.
    task automatic run_load(input int stall_len, input int busy_start_at, input int rst_at,
                            output int done_cyc);
        int   ptr;
        int   stalled;
        logic acc;
        ptr      = 0;
        stalled  = 0;
        done_cyc = -1;
        @(negedge clock); #1;
        start      = 1'b1;
        word_valid = 1'b0;
        @(negedge clock); #1;
        start = 1'b0;
        if (done !== 1'b0 || busy !== 1'b1 || word_ready !== 1'b1)
            $display("FAIL start_ack got done=%0b busy=%0b rdy=%0b exp done=0 busy=1 rdy=1",
                     done, busy, word_ready);
        else n_pass++;
        n_total++;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (done === 1'b1) begin
                done_cyc = cyc - 1;
                break;
            end
            start = (cyc == busy_start_at);
            if (cyc == rst_at) begin
                reset = 1'b1;
                start = 1'b1;
            end
            if (ptr == 10 && stalled < stall_len) begin
                word_valid = 1'b0;
                stalled++;
            end else begin
                word_valid = (ptr < 43);
            end
            word_data = mem[(ptr < 43) ? ptr : 0];
            acc = word_valid & word_ready;
            @(negedge clock); #1;
            if (acc) ptr++;
            if (cyc == rst_at) begin
                done_cyc = -2;
                break;
            end
        end
        start      = 1'b0;
        word_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        if (word_ready !== 1'b0) $display("FAIL rst_word_ready got=%0b exp=0", word_ready); else n_pass++;
        n_total++;
        if (cfg_we !== 1'b0) $display("FAIL rst_cfg_we got=%0b exp=0", cfg_we); else n_pass++;
        n_total++;
        if (cfg_addr !== 5'd0) $display("FAIL rst_cfg_addr got=%0d exp=0", cfg_addr); else n_pass++;
        n_total++;
        if (cfg_data !== 33'd0) $display("FAIL rst_cfg_data got=%h exp=0", cfg_data); else n_pass++;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0)
            $display("FAIL rst_status got busy=%0b done=%0b err=%0b exp 0/0/0", busy, done, error);
        else n_pass++;
        n_total++;
        if (s_ready !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0)
            $display("FAIL rst_small got rdy=%0b busy=%0b done=%0b exp 0/0/0", s_ready, s_busy, s_done);
        else n_pass++;
        n_total++;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock); #1;
    endtask

    task automatic test_full_load(input int stall_len, input int busy_start_at, input int exp_done,
                                  input string tag);
        int          base;
        int          d;
        logic [32:0] exp;
        base = wr_n;
        run_load(stall_len, busy_start_at, 0, d);
        if (d != exp_done) $display("FAIL %s_done_cycle got=%0d exp=%0d", tag, d, exp_done); else n_pass++;
        n_total++;
        if (wr_n - base != 20) $display("FAIL %s_write_count got=%0d exp=20", tag, wr_n - base); else n_pass++;
        n_total++;
        for (int i = 0; i < 20; i++) begin
            exp = {mem[2*i+4][0], mem[2*i+3]};
            if (wr_addr[base+i] !== 5'(i) || wr_data[base+i] !== exp)
                $display("FAIL %s_write%0d got addr=%0d data=%h exp addr=%0d data=%h",
                         tag, i, wr_addr[base+i], wr_data[base+i], i, exp);
            else n_pass++;
            n_total++;
        end
        if (busy !== 1'b0 || error !== 1'b0 || word_ready !== 1'b0)
            $display("FAIL %s_end_status got busy=%0b err=%0b rdy=%0b exp 0/0/0", tag, busy, error, word_ready);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_reset_mid_load;
        int base;
        int d;
        base = wr_n;
        run_load(0, 0, 17, d);
        if (d != -2) $display("FAIL midrst_abort got=%0d exp=-2", d); else n_pass++;
        n_total++;
        if (word_ready !== 1'b0 || cfg_we !== 1'b0 || cfg_addr !== 5'd0 || cfg_data !== 33'd0 ||
            busy !== 1'b0 || done !== 1'b0 || error !== 1'b0)
            $display("FAIL midrst_outputs got rdy=%0b we=%0b addr=%0d data=%h busy=%0b done=%0b err=%0b exp all 0",
                     word_ready, cfg_we, cfg_addr, cfg_data, busy, done, error);
        else n_pass++;
        n_total++;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        if (wr_n - base != 4) $display("FAIL midrst_write_count got=%0d exp=4", wr_n - base); else n_pass++;
        n_total++;
        if (busy !== 1'b0 || word_ready !== 1'b0)
            $display("FAIL midrst_idle got busy=%0b rdy=%0b exp 0/0", busy, word_ready);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_small_inst;
        @(negedge clock); #1;
        s_start = 1'b1;
        @(negedge clock); #1;
        s_start = 1'b0;
        s_valid = 1'b1;
        s_wdata = 32'hDEAD_BEEF;
        if (s_ready !== 1'b1 || s_busy !== 1'b1)
            $display("FAIL small_ready got rdy=%0b busy=%0b exp 1/1", s_ready, s_busy);
        else n_pass++;
        n_total++;
        @(negedge clock); #1;
        s_wdata = 32'hFFFF_FFFF ^ 32'hFFFF_FFFE;
        @(negedge clock); #1;
        s_valid = 1'b0;
        if (s_we !== 1'b1 || s_addr !== 5'd0 || s_cdata !== 33'h1_DEAD_BEEF || s_ready !== 1'b0)
            $display("FAIL small_write got we=%0b addr=%0d data=%h rdy=%0b exp we=1 addr=0 data=1deadbeef rdy=0",
                     s_we, s_addr, s_cdata, s_ready);
        else n_pass++;
        n_total++;
        if (s_done !== 1'b0) $display("FAIL small_done_early got=%0b exp=0", s_done); else n_pass++;
        n_total++;
        @(negedge clock); #1;
        if (s_done !== 1'b1 || s_we !== 1'b0 || s_busy !== 1'b0 || s_cdata !== 33'h1_DEAD_BEEF)
            $display("FAIL small_done got done=%0b we=%0b busy=%0b data=%h exp 1/0/0/1deadbeef",
                     s_done, s_we, s_busy, s_cdata);
        else n_pass++;
        n_total++;
    endtask

`ifdef CFG_PARITY_EN
    task automatic feed(input logic [31:0] w);
        word_valid = 1'b1;
        word_data  = w;
        for (int t = 0; t < 10; t++) begin
            if (word_ready === 1'b1) break;
            @(negedge clock); #1;
        end
        @(negedge clock); #1;
        word_valid = 1'b0;
    endtask

    task automatic test_parity;
        int base;
        base = wr_n;
        @(negedge clock); #1;
        start = 1'b1;
        @(negedge clock); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) feed(32'h5555_0000);
        feed(32'h0000_0001);
        feed(32'h0000_0000);
        @(negedge clock); #1;
        if (error !== 1'b1 || busy !== 1'b0 || wr_n != base)
            $display("FAIL par_err got err=%0b busy=%0b writes=%0d exp 1/0/0", error, busy, wr_n - base);
        else n_pass++;
        n_total++;
        start = 1'b1;
        @(negedge clock); #1;
        start = 1'b0;
        if (error !== 1'b0) $display("FAIL par_err_clear got=%0b exp=0", error); else n_pass++;
        n_total++;
        for (int k = 0; k < 3; k++) feed(32'h5555_0000);
        feed(32'h0000_0001);
        feed(32'h8000_0000);
        @(negedge clock); #1;
        if (wr_n - base != 1 || wr_addr[base] !== 5'd0 || wr_data[base] !== 33'h0_0000_0001)
            $display("FAIL par_ok_write got n=%0d addr=%0d data=%h exp n=1 addr=0 data=000000001",
                     wr_n - base, wr_addr[base], wr_data[base]);
        else n_pass++;
        n_total++;
        reset = 1'b1;
        @(negedge clock); #1;
        reset = 1'b0;
    endtask
`endif

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        word_valid = 1'b0;
        word_data  = 32'd0;
        s_start    = 1'b0;
        s_valid    = 1'b0;
        s_wdata    = 32'd0;
        for (int k = 0; k < 43; k++) begin
            mem[k] = (32'h9E37_79B9 * 32'(k + 1)) ^ 32'(k >> 1);
        end
`ifdef CFG_PARITY_EN
        for (int i = 0; i < 20; i++) begin
            mem[2*i+4][31] = ^{mem[2*i+4][0], mem[2*i+3]};
        end
`endif
        test_reset();
        test_full_load(0, 0, 63, "full");
        test_full_load(5, 0, 68, "stall");
        test_reset_mid_load();
        test_full_load(0, 0, 63, "reload");
        test_full_load(0, 30, 63, "busy_start");
        test_full_load(0, 0, 63, "back_to_back");
        test_small_inst();
`ifdef CFG_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
